get_3x3_window_ram: RTL and testbench
=====================================

Name: get_3x3_window_ram

Overview:
- Parametrised successor to the 1-bit 3x3 window generator; feeds Sobel, erosion, dilation and future grey-scale filters.
- Generalised to DATA_W-bit pixels, with frame-start resync, border handling and an end-of-frame flush.
- Emits one window per input pixel, centred on that pixel, with row/frame markers.
- Line buffers are inferred RAM; no vendor shift-register IP.

Parameters:
- DATA_W, 1, pixel width in bits.
- IMG_W, 1024, active pixels per line (minimum 4).
- IMG_H, 768, active lines per frame (minimum 3).
- BORDER_MODE, 0, how out-of-image taps are filled: 0 = zero, 1 = replicate nearest in-image tap.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- din_en  in  1  input pixel valid
- din_data  in  DATA_W  input pixel, raster order
- din_sof  in  1  qualified by din_en; marks the first pixel of a frame
- dout_en  out  1  window valid, one-cycle pulse
- dout_sof  out  1  with dout_en: window centred on pixel (0,0)
- dout_eol  out  1  with dout_en: centre column is IMG_W-1
- p11,p12,p13,p21,p22,p23,p31,p32,p33  out  DATA_W each  window taps; p22 is the centre, p11 is up-left
- busy  out  1  flush in progress
- err_ovf  out  1  sticky; set when din_en arrives during a flush

Behaviour:
- Reset: every output is 0, counters are 0, line buffers are logically empty, FSM is IDLE. RAM contents are don't-care. Reset mid-frame discards the frame.
- Accepted pixel: a din_en cycle, or an internal flush cycle (flush data = 0). Only accepted pixels advance counters, shift the window and advance the line buffers. All other state holds.
- Counters: col_in wraps at IMG_W-1; row_in increments on that wrap. k = row_in*IMG_W + col_in.
- din_sof with din_en forces this pixel to be k=0 of a new frame (col_in=0, row_in=0). Flush state and any partial frame are dropped.
- Centre pixel: centre index c = k-(IMG_W+1); cr = c / IMG_W, cc = c % IMG_W. A window is produced only when k >= IMG_W+1.
- Latency: all outputs are registered. dout_en, its markers and its taps appear 1 cycle after the accepted pixel that completes the window. The centre pixel is therefore IMG_W+1 accepted pixels old.
- Border flags: top = (cr==0), bottom = (cr==IMG_H-1), left = (cc==0), right = (cc==IMG_W-1). Raw taps wrapped from an adjacent line, or left over from a previous frame, are never output.
  - Zero mode: every out-of-image tap is 0.
  - Replicate mode: each out-of-image tap takes its in-image neighbour. The row index is clamped first, then the column index (corners take the centre-row/column corner pixel).
- FSM:
  - IDLE -> RUN on din_en with din_sof.
  - RUN -> FLUSH after the accepted pixel with k = IMG_W*IMG_H-1.
  - FLUSH: generates exactly IMG_W+1 internal accepted pixels on consecutive cycles with busy=1, then -> IDLE.
  - Exactly IMG_W*IMG_H dout_en pulses per frame.
- din_en without din_sof in IDLE is ignored; no output.
- Overflow: din_en during FLUSH sets err_ovf. If that pixel carries din_sof, a new frame starts; otherwise it is dropped and the flush continues. err_ovf clears only on rst.
- Upstream requirement: vertical blanking >= IMG_W+1 cycles.
- dout_sof and dout_eol are zero whenever dout_en=0. dout_eol and dout_sof coincide only if IMG_W=1, which is disallowed.

Decomposition:
- Package win_pkg:
  - BORDER_ZERO/BORDER_REPL encodings
  - FSM state enum (IDLE, RUN, FLUSH)
  - clog2 helper for the counter widths
- Sub-module line_buffer_ram:
  - Parameters DATA_W, DEPTH=IMG_W.
  - Inferred simple dual-port RAM plus a circular address counter.
  - Read-before-write, advances on clken, 1-cycle delay-line semantics.
  - Two instances are chained, giving row-1 and row-2 taps.

Test Plan:
Common setup for all scenarios: DATA_W=8, IMG_W=4, IMG_H=3, pixel value = raster index+1 (1..12), din_en continuous.
- Zero mode: first dout_en comes 1 cycle after the 6th input pixel, with dout_sof=1. Taps: p11=p12=p13=p21=p31=0, p22=1, p23=2, p32=5, p33=6.
- Replicate mode, centre (0,0): p11=1, p12=1, p13=2, p21=1, p22=1, p23=2, p31=5, p32=5, p33=6.
- Interior centre (1,1), either mode: taps p11..p33 = 1,2,3,5,6,7,9,10,11. dout_eol is 1 on windows 4, 8 and 12 only.
- Flush, replicate mode: after pixel 12, busy=1 for exactly 5 cycles. The 12th window has p22=12 and taps 7,8,8,11,12,12,11,12,12. The total dout_en count is 12.
- Stall: random din_en gaps of 0-3 cycles. Windows must match the no-gap run exactly; taps hold between pulses.
- Error and reset:
  - din_en without sof during FLUSH -> err_ovf=1; flush still completes.
  - Next frame with din_sof -> correct first window.
  - rst mid-frame -> all outputs 0 next cycle; err_ovf cleared.

Source files
------------

// File: rtl/win_pkg.sv
// Shared encodings and helpers for the 3x3 window generator and its line buffers.
package win_pkg;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/get_3x3_window_ram_line_buffer.sv
// One-line delay built on an inferred simple dual-port RAM; dout is the pixel
// accepted DEPTH clken cycles earlier, valid before the next clken edge.
module line_buffer_ram
  import win_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     addr;
  logic [AW-1:0]     addr_nxt;
  logic [AW-1:0]     rd_addr;

  // Read one slot ahead so the oldest entry is already registered when the
  // next pixel arrives, however long the gap between accepts.
  always_comb begin
    addr_nxt = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
    rd_addr  = clken ? addr_nxt : addr;
  end

  always_ff @(posedge clk) begin
    if (clken) mem[addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      dout <= '0;
    end else begin
      dout <= mem[rd_addr];
      if (clken) addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/get_3x3_window_ram.sv
// Raster-order 3x3 window generator with border fill, frame resync and an
// end-of-frame flush that drains the last IMG_W+1 windows.
//   state    | meaning
//   ST_IDLE  | waiting for din_sof, other pixels ignored
//   ST_RUN   | accepting frame pixels
//   ST_FLUSH | injecting IMG_W+1 zero pixels, busy=1
module get_3x3_window_ram
  import win_pkg::*;
#(
  parameter int DATA_W      = 1,
  parameter int IMG_W       = 1024,
  parameter int IMG_H       = 768,
  parameter int BORDER_MODE = BORDER_ZERO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_en,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_sof,
  output logic              dout_en,
  output logic              dout_sof,
  output logic              dout_eol,
  output logic [DATA_W-1:0] p11, p12, p13,
  output logic [DATA_W-1:0] p21, p22, p23,
  output logic [DATA_W-1:0] p31, p32, p33,
  output logic              busy,
  output logic              err_ovf
);

  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H + 2);
  localparam int FW = clog2(IMG_W + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     col_in, pos_col, cc;
  logic [RW-1:0]     row_in, pos_row, cr;
  logic [FW-1:0]     fl_cnt;
  logic              sof_acc, run_acc, flush_acc, acc, last_col, win_ok;
  logic              top, bot, left, right;
  logic [DATA_W-1:0] pix, lb1_q, lb2_q;
  logic [DATA_W-1:0] w  [3][3];
  logic [DATA_W-1:0] nw [3][3];
  logic [DATA_W-1:0] m  [3][3];

  line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst(rst), .clken(acc), .din(pix), .dout(lb1_q)
  );

  line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .rst(rst), .clken(acc), .din(lb1_q), .dout(lb2_q)
  );

  always_comb begin
    sof_acc   = din_en & din_sof;
    run_acc   = (state == ST_RUN) & din_en & ~din_sof;
    flush_acc = (state == ST_FLUSH) & ~sof_acc;
    acc       = sof_acc | run_acc | flush_acc;
    pix       = flush_acc ? '0 : din_data;
    pos_col   = sof_acc ? '0 : col_in;
    pos_row   = sof_acc ? '0 : row_in;
    last_col  = (pos_col == CW'(IMG_W - 1));
    win_ok    = acc & ((pos_row >= RW'(2)) | ((pos_row == RW'(1)) & (pos_col != '0)));
    // Centre lags the incoming pixel by one line plus one pixel.
    cc        = (pos_col == '0) ? CW'(IMG_W - 1) : pos_col - CW'(1);
    cr        = (pos_col == '0) ? pos_row - RW'(2) : pos_row - RW'(1);
    top       = (cr == '0);
    bot       = (cr == RW'(IMG_H - 1));
    left      = (cc == '0);
    right     = (cc == CW'(IMG_W - 1));

    state_nxt = state;
    case (state)
      ST_IDLE:  if (sof_acc) state_nxt = ST_RUN;
      ST_RUN: begin
        if (sof_acc) state_nxt = ST_RUN;
        else if (run_acc && last_col && pos_row == RW'(IMG_H - 1)) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (sof_acc) state_nxt = ST_RUN;
        else if (fl_cnt == '0) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = w[r][1];
      nw[r][1] = w[r][2];
    end
    nw[0][2] = lb2_q;
    nw[1][2] = lb1_q;
    nw[2][2] = pix;

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = nw[r][c];

    // Rows are clamped before columns so corners pick up the centre-row pixel.
    if (BORDER_MODE == BORDER_REPL) begin
      if (top) for (int c = 0; c < 3; c++) m[0][c] = m[1][c];
      if (bot) for (int c = 0; c < 3; c++) m[2][c] = m[1][c];
      if (left)  for (int r = 0; r < 3; r++) m[r][0] = m[r][1];
      if (right) for (int r = 0; r < 3; r++) m[r][2] = m[r][1];
    end else begin
      if (top) for (int c = 0; c < 3; c++) m[0][c] = '0;
      if (bot) for (int c = 0; c < 3; c++) m[2][c] = '0;
      if (left)  for (int r = 0; r < 3; r++) m[r][0] = '0;
      if (right) for (int r = 0; r < 3; r++) m[r][2] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      col_in   <= '0;
      row_in   <= '0;
      fl_cnt   <= '0;
      busy     <= 1'b0;
      err_ovf  <= 1'b0;
      dout_en  <= 1'b0;
      dout_sof <= 1'b0;
      dout_eol <= 1'b0;
      {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_FLUSH);
      if (din_en && state == ST_FLUSH) err_ovf <= 1'b1;

      if (acc) begin
        col_in <= last_col ? '0 : pos_col + CW'(1);
        row_in <= last_col ? pos_row + RW'(1) : pos_row;
        w      <= nw;
      end

      if (state == ST_RUN && state_nxt == ST_FLUSH) fl_cnt <= FW'(IMG_W);
      else if (flush_acc && fl_cnt != '0)           fl_cnt <= fl_cnt - FW'(1);

      dout_en  <= win_ok;
      dout_sof <= win_ok & top & left;
      dout_eol <= win_ok & right;
      if (win_ok) begin
        {p11, p12, p13} <= {m[0][0], m[0][1], m[0][2]};
        {p21, p22, p23} <= {m[1][0], m[1][1], m[1][2]};
        {p31, p32, p33} <= {m[2][0], m[2][1], m[2][2]};
      end
    end
  end

endmodule

// File: tb/tb_get_3x3_window_ram.sv
// Drives a 4x3 frame of 8-bit pixels into a zero-fill and a replicate-fill
// instance side by side and compares every window with a hand-built table.
module tb_get_3x3_window_ram;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int NPIX   = IMG_W * IMG_H;

  typedef struct {
    logic [7:0]  pix;
    logic        sof_in;
    logic        exp_sof;
    logic        exp_eol;
    logic [71:0] z;
    logic [71:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_en = 1'b0;
  logic din_sof = 1'b0;
  logic [7:0] din_data = '0;

  logic en_z, sof_z, eol_z, busy_z, ovf_z;
  logic en_r, sof_r, eol_r, busy_r, ovf_r;
  logic [7:0] z11, z12, z13, z21, z22, z23, z31, z32, z33;
  logic [7:0] r11, r12, r13, r21, r22, r23, r31, r32, r33;

  vec_t tbl [NPIX];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   idx_z   = 0;
  int   idx_r   = 0;
  logic mon_on  = 1'b0;

  always #5 clk = ~clk;

  get_3x3_window_ram #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER_MODE(0)) dut_z (
    .clk(clk), .rst(rst), .din_en(din_en), .din_data(din_data), .din_sof(din_sof),
    .dout_en(en_z), .dout_sof(sof_z), .dout_eol(eol_z),
    .p11(z11), .p12(z12), .p13(z13), .p21(z21), .p22(z22), .p23(z23),
    .p31(z31), .p32(z32), .p33(z33), .busy(busy_z), .err_ovf(ovf_z)
  );

  get_3x3_window_ram #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .din_en(din_en), .din_data(din_data), .din_sof(din_sof),
    .dout_en(en_r), .dout_sof(sof_r), .dout_eol(eol_r),
    .p11(r11), .p12(r12), .p13(r13), .p21(r21), .p22(r22), .p23(r23),
    .p31(r31), .p32(r32), .p33(r33), .busy(busy_r), .err_ovf(ovf_r)
  );

  function automatic logic [71:0] w9(input int a, b, c, d, e, f, g, h, i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic s);
    din_en = 1'b1; din_data = d; din_sof = s;
    @(posedge clk); #1;
    din_en = 1'b0; din_data = '0; din_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int inject_at, output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy_z) n++;
      if (c == inject_at) begin din_en = 1'b1; din_data = 8'd99; end
      @(posedge clk); #1;
      din_en = 1'b0; din_data = '0;
    end
  endtask

  task automatic run_frame_cont(input string tag);
    idx_z = 0; idx_r = 0;
    for (int i = 0; i < NPIX; i++) begin
      put(tbl[i].pix, tbl[i].sof_in);
      check({tag, "_en_timing"}, {78'(0), en_z, en_r}, {78'(0), (i >= 5), (i >= 5)});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {en_z, sof_z, eol_z, busy_z, ovf_z, en_r, sof_r, eol_r, busy_r, ovf_r},
          80'(0));
    check({tag, "_taps"}, {8'(0), z11, z12, z13, z21, z22, z23, z31, z32, z33}, 80'(0));
    check({tag, "_taps_r"}, {8'(0), r11, r12, r13, r21, r22, r23, r31, r32, r33}, 80'(0));
  endtask

  initial begin
    int n;
    tbl[0]  = '{8'd1,  1'b1, 1'b1, 1'b0, w9(0,0,0, 0,1,2, 0,5,6),    w9(1,1,2, 1,1,2, 5,5,6)};
    tbl[1]  = '{8'd2,  1'b0, 1'b0, 1'b0, w9(0,0,0, 1,2,3, 5,6,7),    w9(1,2,3, 1,2,3, 5,6,7)};
    tbl[2]  = '{8'd3,  1'b0, 1'b0, 1'b0, w9(0,0,0, 2,3,4, 6,7,8),    w9(2,3,4, 2,3,4, 6,7,8)};
    tbl[3]  = '{8'd4,  1'b0, 1'b0, 1'b1, w9(0,0,0, 3,4,0, 7,8,0),    w9(3,4,4, 3,4,4, 7,8,8)};
    tbl[4]  = '{8'd5,  1'b0, 1'b0, 1'b0, w9(0,1,2, 0,5,6, 0,9,10),   w9(1,1,2, 5,5,6, 9,9,10)};
    tbl[5]  = '{8'd6,  1'b0, 1'b0, 1'b0, w9(1,2,3, 5,6,7, 9,10,11),  w9(1,2,3, 5,6,7, 9,10,11)};
    tbl[6]  = '{8'd7,  1'b0, 1'b0, 1'b0, w9(2,3,4, 6,7,8, 10,11,12), w9(2,3,4, 6,7,8, 10,11,12)};
    tbl[7]  = '{8'd8,  1'b0, 1'b0, 1'b1, w9(3,4,0, 7,8,0, 11,12,0),  w9(3,4,4, 7,8,8, 11,12,12)};
    tbl[8]  = '{8'd9,  1'b0, 1'b0, 1'b0, w9(0,5,6, 0,9,10, 0,0,0),   w9(5,5,6, 9,9,10, 9,9,10)};
    tbl[9]  = '{8'd10, 1'b0, 1'b0, 1'b0, w9(5,6,7, 9,10,11, 0,0,0),  w9(5,6,7, 9,10,11, 9,10,11)};
    tbl[10] = '{8'd11, 1'b0, 1'b0, 1'b0, w9(6,7,8, 10,11,12, 0,0,0), w9(6,7,8, 10,11,12, 10,11,12)};
    tbl[11] = '{8'd12, 1'b0, 1'b0, 1'b1, w9(7,8,0, 11,12,0, 0,0,0),  w9(7,8,8, 11,12,12, 11,12,12)};

    // Window monitor: checks each pulse against the table and that taps hold between pulses.
    fork
      forever begin
        @(negedge clk);
        if (mon_on && !rst) begin
          if (en_z) begin
            if (idx_z < NPIX)
              check("win_zero", {6'(0), sof_z, eol_z, z11, z12, z13, z21, z22, z23, z31, z32, z33},
                    {6'(0), tbl[idx_z].exp_sof, tbl[idx_z].exp_eol, tbl[idx_z].z});
            else check("extra_win_zero", 80'(idx_z), 80'(NPIX - 1));
            idx_z++;
          end else if (idx_z > 0 && idx_z <= NPIX) begin
            check("hold_zero", {8'(0), z11, z12, z13, z21, z22, z23, z31, z32, z33},
                  {8'(0), tbl[idx_z - 1].z});
          end
          if (en_r) begin
            if (idx_r < NPIX)
              check("win_repl", {6'(0), sof_r, eol_r, r11, r12, r13, r21, r22, r23, r31, r32, r33},
                    {6'(0), tbl[idx_r].exp_sof, tbl[idx_r].exp_eol, tbl[idx_r].r});
            else check("extra_win_repl", 80'(idx_r), 80'(NPIX - 1));
            idx_r++;
          end else if (idx_r > 0 && idx_r <= NPIX) begin
            check("hold_repl", {8'(0), r11, r12, r13, r21, r22, r23, r31, r32, r33},
                  {8'(0), tbl[idx_r - 1].r});
          end
        end
      end
    join_none

    idle(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);
    mon_on = 1'b1;

    // Continuous frame then flush.
    run_frame_cont("f1");
    count_busy(-1, n);
    check("f1_busy_cycles", 80'(n), 80'(5));
    check("f1_win_count", {40'(idx_z), 40'(idx_r)}, {40'(NPIX), 40'(NPIX)});
    check("f1_no_ovf", {78'(0), ovf_z, ovf_r}, 80'(0));

    // Pixels without sof while idle produce nothing.
    idx_z = 0; idx_r = 0;
    for (int i = 0; i < 8; i++) put(8'(i + 50), 1'b0);
    idle(2);
    check("idle_ignored", {40'(idx_z), 40'(idx_r)}, 80'(0));

    // Stalled frame with random gaps of 0-3 cycles.
    idx_z = 0; idx_r = 0;
    for (int i = 0; i < NPIX; i++) begin
      put(tbl[i].pix, tbl[i].sof_in);
      idle($urandom_range(0, 3));
    end
    idle(IMG_W + 4);
    check("stall_win_count", {40'(idx_z), 40'(idx_r)}, {40'(NPIX), 40'(NPIX)});

    // Overflow during flush: flag sets, flush still completes.
    run_frame_cont("f3");
    count_busy(1, n);
    check("ovf_busy_cycles", 80'(n), 80'(5));
    check("ovf_set", {78'(0), ovf_z, ovf_r}, {78'(0), 2'b11});
    check("ovf_win_count", {40'(idx_z), 40'(idx_r)}, {40'(NPIX), 40'(NPIX)});

    // Next frame recovers and overflow stays sticky.
    run_frame_cont("f4");
    idle(IMG_W + 4);
    check("f4_win_count", {40'(idx_z), 40'(idx_r)}, {40'(NPIX), 40'(NPIX)});
    check("ovf_sticky", {78'(0), ovf_z, ovf_r}, {78'(0), 2'b11});

    // Reset in the middle of a frame.
    idx_z = 0; idx_r = 0;
    for (int i = 0; i < 7; i++) put(tbl[i].pix, tbl[i].sof_in);
    mon_on = 1'b0;
    rst = 1'b1;
    din_en = 1'b1; din_data = 8'd77;
    idle(1);
    din_en = 1'b0; din_data = '0;
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    idle(1);
    check("post_reset_idle", {78'(0), en_z, en_r}, 80'(0));

    // Clean frame after reset.
    idx_z = 0; idx_r = 0;
    mon_on = 1'b1;
    run_frame_cont("f5");
    idle(IMG_W + 4);
    check("f5_win_count", {40'(idx_z), 40'(idx_r)}, {40'(NPIX), 40'(NPIX)});

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
